// File: rtl/regbank_pkg.sv
// rtl/regbank_pkg.sv - shared state type and default sizes for the register bank
package regbank_pkg;

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/reg_bank_sb.sv
// rtl/reg_bank_sb.sv - register bank with bypass, hardwired R0, pending-write scoreboard, bulk clear
module reg_bank_sb
  import regbank_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = 2,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     sb_set,
  input  logic [AW-1:0]            sb_addr,
  input  logic                     clr_req,
  output logic                     clr_busy
);

  localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  // R0 and out-of-range addresses are neither stored nor tracked
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < DEPTH_X);
  endfunction

  state_t            state, state_nxt;
  logic [AW-1:0]     idx, idx_nxt;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              idle, wr_ok, sb_ok;

  assign idle     = (state == IDLE);
  assign wr_ok    = idle && wr_en && addr_ok(wr_addr);
  assign sb_ok    = idle && sb_set && addr_ok(sb_addr);
  assign clr_busy = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (clr_req && (DEPTH > 1)) begin
          state_nxt = CLEAR;
          idx_nxt   = AW'(1);
        end
      end
      CLEAR: begin
        if (idx == LAST) state_nxt = IDLE;
        else             idx_nxt   = idx + AW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      pend  <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (clr_busy) begin
        regs[idx] <= '0;
        pend[idx] <= 1'b0;
      end else begin
        if (wr_ok) begin
          regs[wr_addr] <= wr_data;
          pend[wr_addr] <= 1'b0;
        end
        // issued after the write in program order so a same-address set wins
        if (sb_ok) pend[sb_addr] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[g*AW +: AW];
    assign rd_data[g*DATA_W +: DATA_W] =
        !addr_ok(a)                   ? '0      :
        (idle && wr_en && wr_addr == a) ? wr_data :
                                          regs[a];
    assign rd_busy[g] = addr_ok(a) && pend[a];
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb/tb_reg_bank_sb.sv - scoreboard bench driving a 32x16x2 and a 64x12x4 bank from one stimulus stream
module tb_reg_bank_sb;

  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [4*AW-1:0]   rd_addr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [63:0]       wr_data;
  logic              sb_set;
  logic [AW-1:0]     sb_addr;
  logic              clr_req;
  logic [2*32-1:0]   rd_data0;
  logic [1:0]        rd_busy0;
  logic              clr_busy0;
  logic [4*64-1:0]   rd_data1;
  logic [3:0]        rd_busy1;
  logic              clr_busy1;

  always #5 clk = ~clk;

  reg_bank_sb #(.DATA_W(32), .DEPTH(16), .NUM_RD(2)) u0 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr[2*AW-1:0]), .rd_data(rd_data0),
    .rd_busy(rd_busy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
    .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req), .clr_busy(clr_busy0)
  );

  reg_bank_sb #(.DATA_W(64), .DEPTH(12), .NUM_RD(4)) u1 (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_busy(rd_busy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set(sb_set), .sb_addr(sb_addr), .clr_req(clr_req), .clr_busy(clr_busy1)
  );

  // Reference model: one array of values and pending flags per instance
  int          depth [2] = '{16, 12};
  int          nrd   [2] = '{2, 4};
  logic [63:0] mask  [2] = '{64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [63:0] m_reg [2][16];
  bit          m_pend[2][16];
  bit          m_clr [2];
  int          m_idx [2];

  typedef struct packed {
    logic [1:0][3:0][63:0] data;
    logic [1:0][3:0]       busy;
    logic [1:0]            clr;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_clr[k] = 1'b0;
      m_idx[k] = 0;
      for (int a = 0; a < 16; a++) begin
        m_reg[k][a]  = '0;
        m_pend[k][a] = 1'b0;
      end
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    e = '0;
    for (int k = 0; k < 2; k++) begin
      e.clr[k] = m_clr[k];
      for (int p = 0; p < 4; p++) begin
        int a;
        a = int'(rd_addr[p*AW +: AW]);
        if (p < nrd[k] && a != 0 && a < depth[k]) begin
          e.busy[k][p] = m_pend[k][a];
          if (!m_clr[k] && wr_en && int'(wr_addr) == a) e.data[k][p] = wr_data & mask[k];
          else                                            e.data[k][p] = m_reg[k][a];
        end
      end
    end
    return e;
  endfunction

  task automatic model_edge();
    int wa, sa;
    wa = int'(wr_addr);
    sa = int'(sb_addr);
    for (int k = 0; k < 2; k++) begin
      if (m_clr[k]) begin
        m_reg[k][m_idx[k]]  = '0;
        m_pend[k][m_idx[k]] = 1'b0;
        if (m_idx[k] == depth[k] - 1) m_clr[k] = 1'b0;
        else                          m_idx[k]++;
      end else begin
        if (wr_en && wa != 0 && wa < depth[k]) begin
          m_reg[k][wa]  = wr_data & mask[k];
          m_pend[k][wa] = 1'b0;
        end
        if (sb_set && sa != 0 && sa < depth[k]) m_pend[k][sa] = 1'b1;
        if (clr_req && depth[k] > 1) begin
          m_clr[k] = 1'b1;
          m_idx[k] = 1;
        end
      end
    end
  endtask

  // Inputs are set just after a rising edge; the expectation for the
  // following falling edge is queued, then the model advances on the edge.
  task automatic cycle();
    q.push_back(predict());
    @(posedge clk);
    if (reset) model_edge();
    #1;
  endtask

  task automatic idle_in();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    sb_set  = 1'b0;
    sb_addr = '0;
    clr_req = 1'b0;
  endtask

  task automatic sweep();
    idle_in();
    for (int b = 0; b < 16; b += 2) begin
      for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = AW'(b + p);
      cycle();
    end
  endtask

  task automatic fill();
    idle_in();
    for (int i = 1; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = 64'(i);
      cycle();
    end
    idle_in();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    idle_in();
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d_clr_busy", k), 64'(k == 0 ? clr_busy0 : clr_busy1), 64'(mon_e.clr[k]));
        for (int p = 0; p < nrd[k]; p++) begin
          chk($sformatf("u%0d_rd_data%0d", k, p),
              k == 0 ? {32'h0, rd_data0[p*32 +: 32]} : rd_data1[p*64 +: 64], mon_e.data[k][p]);
          chk($sformatf("u%0d_rd_busy%0d", k, p),
              64'(k == 0 ? rd_busy0[p] : rd_busy1[p]), 64'(mon_e.busy[k][p]));
        end
      end
    end
  end

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    idle_in();
    model_reset();
    @(posedge clk);
    #1;
    apply_reset();
    sweep();

    // bypass then stored value
    rd_addr = {AW'(5), AW'(5), AW'(0), AW'(5)};
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 64'hDEAD_BEEF;
    cycle();
    idle_in();
    cycle();

    // R0 stays zero; addr 15 is dropped in the 12-deep bank only
    rd_addr = {AW'(15), AW'(0), AW'(15), AW'(0)};
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = 64'h1234;
    cycle();
    wr_addr = AW'(15); wr_data = 64'hA5A5_0000_0000_5A5A;
    cycle();
    idle_in();
    cycle();

    // scoreboard set, clear by write, set-wins collision
    rd_addr = {AW'(3), AW'(3), AW'(3), AW'(3)};
    sb_set = 1'b1; sb_addr = AW'(3);
    cycle();
    idle_in();
    cycle();
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 64'h33;
    cycle();
    idle_in();
    cycle();
    sb_set = 1'b1; sb_addr = AW'(3); wr_en = 1'b1; wr_addr = AW'(3); wr_data = 64'h44;
    cycle();
    idle_in();
    cycle();

    // full bulk clear with ignored traffic during CLEAR
    fill();
    sb_set = 1'b1; sb_addr = AW'(7);
    cycle();
    idle_in();
    clr_req = 1'b1;
    cycle();
    for (int j = 0; j < 15; j++) begin
      rd_addr = 16'($urandom);
      if (j < 10) begin
        wr_en   = 1'b1;
        wr_addr = AW'($urandom);
        wr_data = {$urandom, $urandom};
        sb_set  = 1'b1;
        sb_addr = AW'($urandom);
        clr_req = 1'b1;
      end else begin
        idle_in();
      end
      cycle();
    end
    sweep();

    // reset in the middle of a clear
    fill();
    sb_set = 1'b1; sb_addr = AW'(9);
    cycle();
    idle_in();
    clr_req = 1'b1;
    cycle();
    idle_in();
    for (int j = 0; j < 5; j++) begin
      rd_addr = 16'($urandom);
      cycle();
    end
    apply_reset();
    sweep();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(299) == 0) begin
        apply_reset();
      end else begin
        rd_addr = 16'($urandom);
        wr_en   = ($urandom_range(2) != 0);
        wr_addr = AW'($urandom);
        wr_data = {$urandom, $urandom};
        sb_set  = ($urandom_range(2) == 0);
        sb_addr = AW'($urandom);
        clr_req = ($urandom_range(39) == 0);
        cycle();
      end
    end
    sweep();

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
